logic_gate_pipe: RTL

Parametrised, pipelined successor to the team's fixed 1-bit NOT/NAND/OR gate block. It applies one of eight selectable bitwise logic functions to four WIDTH-bit operand vectors and registers the result behind a two-stage valid/ready pipeline. It also produces reduction flags. It sits between operand producers and consumers in the datapath, and any upstream or downstream stage may stall it.

---
 rtl/logic_gate_pipe.sv | 119 +++++++++++
 1 files changed

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: eight-function bitwise logic unit behind a two-stage valid/ready pipeline.
// Define LOGIC_GATE_PIPE_STATS_EN to add the saturating o_out_count accepted-result counter.
module logic_gate_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_y,
    output logic             o_y_any,
    output logic             o_y_all
`ifdef LOGIC_GATE_PIPE_STATS_EN
    ,
    output logic [15:0]      o_out_count
`endif
);

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [WIDTH-1:0] r_s1_c;
    logic [WIDTH-1:0] r_s1_d;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_y_any;
    logic             r_y_all;

    logic             w_s2_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_fn;
    logic [WIDTH-1:0] w_nand_bc;

    // S2 may take S1 whenever its own slot is free or being drained this cycle.
    assign w_s2_adv   = r_s1_valid & (~r_out_valid | i_out_ready);
    assign o_in_ready = ~r_s1_valid | w_s2_adv;
    assign w_accept   = i_in_valid & o_in_ready;

    assign w_nand_bc = ~(r_s1_b & r_s1_c);

    always_comb begin
        w_fn = '0;
        case (r_s1_op)
            3'd0:    w_fn = ~r_s1_a;
            3'd1:    w_fn = w_nand_bc;
            3'd2:    w_fn = w_nand_bc | r_s1_d;
            3'd3:    w_fn = ~r_s1_a & (w_nand_bc | r_s1_d);
            3'd4:    w_fn = r_s1_a & r_s1_b;
            3'd5:    w_fn = r_s1_a ^ r_s1_b;
            3'd6:    w_fn = ~(r_s1_a ^ r_s1_b);
            default: w_fn = r_s1_a;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_d     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= i_op;
            r_s1_a     <= i_a;
            r_s1_b     <= i_b;
            r_s1_c     <= i_c;
            r_s1_d     <= i_d;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_y_any     <= 1'b0;
            r_y_all     <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= 1'b1;
            r_y         <= w_fn;
            r_y_any     <= |w_fn;
            r_y_all     <= &w_fn;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_y         = r_y;
    assign o_y_any     = r_y_any;
    assign o_y_all     = r_y_all;

`ifdef LOGIC_GATE_PIPE_STATS_EN
    logic [15:0] r_out_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_count <= '0;
        end else if (r_out_valid && i_out_ready && (r_out_count != 16'hFFFF)) begin
            r_out_count <= r_out_count + 16'd1;
        end
    end

    assign o_out_count = r_out_count;
`endif

endmodule
